// File: rtl/scoreboard.sv
// Register scoreboard: per-register pending-write counters gating instruction issue,
// plus a RUN/DRAIN serialization FSM. Define SB_WB_BYPASS_EN to let a same-cycle
// writeback count as retired for the issue hazard checks.
module scoreboard (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic        iss_en_rs1,
  input  logic        iss_en_rs2,
  input  logic [4:0]  iss_rd,
  input  logic        iss_en_rd,
  output logic        iss_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  input  logic        drain_req,
  output logic        drain_done,
  output logic [31:0] busy_vec,
  output logic [6:0]  outstanding,
  output logic        sb_err
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t     state;
  logic [1:0] cnt [32];
  logic [1:0] c_rs1, c_rs2, c_rd;
  logic       inc, wb_ok, wb_bad;

  assign wb_ok  = wb_valid && (wb_rd != '0) && (cnt[wb_rd] != '0);
  assign wb_bad = wb_valid && (wb_rd != '0) && (cnt[wb_rd] == '0);
  assign inc    = iss_valid && iss_ready && iss_en_rd && (iss_rd != '0);

  always_comb begin
    c_rs1 = cnt[iss_rs1];
    c_rs2 = cnt[iss_rs2];
    c_rd  = cnt[iss_rd];
`ifdef SB_WB_BYPASS_EN
    // wb_ok already implies a nonzero index and counter, so the decrement cannot wrap
    if (wb_ok && (wb_rd == iss_rs1)) c_rs1 = c_rs1 - 2'd1;
    if (wb_ok && (wb_rd == iss_rs2)) c_rs2 = c_rs2 - 2'd1;
    if (wb_ok && (wb_rd == iss_rd))  c_rd  = c_rd  - 2'd1;
`endif
    iss_ready = (state == RUN) && !flush
             && !(iss_en_rs1 && (iss_rs1 != '0) && (c_rs1 != '0))
             && !(iss_en_rs2 && (iss_rs2 != '0) && (c_rs2 != '0))
             && !(iss_en_rd  && (iss_rd  != '0) && (c_rd  == 2'd3));
  end

  always_comb begin
    busy_vec = '0;
    for (int unsigned i = 1; i < 32; i++) busy_vec[i] = (cnt[i] != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 32; i++) cnt[i] <= '0;
      outstanding <= '0;
      sb_err      <= 1'b0;
    end else if (flush) begin
      for (int unsigned i = 0; i < 32; i++) cnt[i] <= '0;
      outstanding <= '0;
    end else begin
      // an issue and a writeback to the same register cancel out
      for (int unsigned i = 1; i < 32; i++) begin
        case ({inc && (iss_rd == i[4:0]), wb_ok && (wb_rd == i[4:0])})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: ;
        endcase
      end
      outstanding <= outstanding + {6'd0, inc} - {6'd0, wb_ok};
      if (wb_bad) sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else if (flush) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        RUN: begin
          // with nothing outstanding the drain enters and exits in one step
          if (drain_req) begin
            if (outstanding == '0) drain_done <= 1'b1;
            else                   state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state      <= RUN;
            drain_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Scoreboard bench: driver pushes expected outputs from a pending-count model into a
// queue; a negedge monitor pops and compares. Honours SB_WB_BYPASS_EN like the RTL.
module tb_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iss_valid, iss_en_rs1, iss_en_rs2, iss_en_rd;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush, drain_req, drain_done, sb_err;
  logic [31:0] busy_vec;
  logic [6:0]  outstanding;

  scoreboard dut (
    .clk(clk), .reset_n(reset_n), .iss_valid(iss_valid),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_en_rs1(iss_en_rs1), .iss_en_rs2(iss_en_rs2),
    .iss_rd(iss_rd), .iss_en_rd(iss_en_rd), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .drain_req(drain_req),
    .drain_done(drain_done), .busy_vec(busy_vec), .outstanding(outstanding), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        ready;
    bit [31:0] busy;
    int        outs;
    bit        err;
    bit        done;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  // reference model: pending writes per register, drain flag, sticky error
  int pend [32];
  bit m_drain, m_done, m_err;
  bit rst_drv_n;

  function automatic int m_total();
    int t = 0;
    for (int r = 0; r < 32; r++) t += pend[r];
    return t;
  endfunction

  function automatic bit [31:0] m_busy();
    bit [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (pend[r] > 0);
    return b;
  endfunction

  function automatic int eff(input logic [4:0] r);
    int v = pend[r];
`ifdef SB_WB_BYPASS_EN
    if (wb_valid && wb_rd == r && r != 0 && v > 0) v = v - 1;
`endif
    return v;
  endfunction

  function automatic bit m_ready();
    if (m_drain || flush) return 1'b0;
    if (iss_en_rs1 && iss_rs1 != 0 && eff(iss_rs1) > 0) return 1'b0;
    if (iss_en_rs2 && iss_rs2 != 0 && eff(iss_rs2) > 0) return 1'b0;
    if (iss_en_rd && iss_rd != 0 && eff(iss_rd) >= 3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    m_drain = 0; m_done = 0; m_err = 0;
  endtask

  task automatic m_step(input bit rdy);
    int tot = m_total();
    bit dec = 0;
    if (flush) begin
      for (int r = 0; r < 32; r++) pend[r] = 0;
      m_drain = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (!m_drain) begin
      if (drain_req) begin
        if (tot == 0) m_done = 1;
        else          m_drain = 1;
      end
    end else if (tot == 0) begin
      m_drain = 0; m_done = 1;
    end
    if (wb_valid && wb_rd != 0) begin
      if (pend[wb_rd] == 0) m_err = 1;
      else                  dec = 1;
    end
    if (iss_valid && rdy && iss_en_rd && iss_rd != 0) pend[iss_rd] = pend[iss_rd] + 1;
    if (dec) pend[wb_rd] = pend[wb_rd] - 1;
  endtask

  task automatic cyc(input bit v, input logic [4:0] rs1, input bit e1, input logic [4:0] rs2,
                     input bit e2, input logic [4:0] rd, input bit erd, input bit wv,
                     input logic [4:0] wr, input bit fl, input bit dr);
    exp_t x;
    iss_valid = v; iss_rs1 = rs1; iss_en_rs1 = e1; iss_rs2 = rs2; iss_en_rs2 = e2;
    iss_rd = rd; iss_en_rd = erd; wb_valid = wv; wb_rd = wr; flush = fl; drain_req = dr;
    reset_n = rst_drv_n;
    if (!reset_n) m_reset();
    x.ready = m_ready();
    x.busy  = m_busy();
    x.outs  = m_total();
    x.err   = m_err;
    x.done  = m_done;
    q.push_back(x);
    @(posedge clk);
    if (reset_n) m_step(x.ready);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check("iss_ready",   {31'd0, iss_ready},  {31'd0, e.ready});
      check("busy_vec",    busy_vec,            e.busy);
      check("outstanding", {25'd0, outstanding}, e.outs);
      check("sb_err",      {31'd0, sb_err},     {31'd0, e.err});
      check("drain_done",  {31'd0, drain_done}, {31'd0, e.done});
    end
  end

  function automatic logic [4:0] rreg();
    if ($urandom_range(0, 15) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 6));
  endfunction

  bit dr_lvl;

  initial begin
    reset_n = 1'b0; iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_en_rs1 = 0; iss_en_rs2 = 0;
    iss_rd = 0; iss_en_rd = 0; wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
    m_reset();
    rst_drv_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle();                                   // reset state
    rst_drv_n = 1'b1;
    idle();

    // RAW on r5 resolved by writeback
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // saturation on r7
    repeat (3) cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);

    // same-cycle issue and writeback on r9
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 0);
    idle();

    // stray writebacks
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();

    // flush then bypass case on r3
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 3, 1, 0, 0, 1, 3, 0, 0);
    idle();

    // drain with two pending writes, then immediate drain with none
    cyc(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 10, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 11, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    idle();

    // reset mid-drain: no drain_done afterwards
    cyc(1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 1);
    rst_drv_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_drv_n = 1'b1;
    idle();
    idle();

    // randomized traffic
    dr_lvl = 0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 39) == 0) dr_lvl = ~dr_lvl;
      rst_drv_n = ($urandom_range(0, 499) != 0);
      cyc($urandom_range(0, 9) < 7, rreg(), $urandom_range(0, 3) == 0, rreg(),
          $urandom_range(0, 3) == 0, rreg(), $urandom_range(0, 7) != 0,
          $urandom_range(0, 9) < 3, rreg(), $urandom_range(0, 63) == 0, dr_lvl);
    end
    rst_drv_n = 1'b1;
    idle();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
